// File: rtl/key_dev.sv
// Operand entry front-end: synchronizes switches/buttons, debounces buttons and drives a 4-state ALU request FSM.
// Build with KEY_DEV_DEBOUNCE_EN defined to include the per-button debounce counters.
module key_dev #(
   parameter int DEBOUNCE_CYCLES = 50000,
   parameter int CNT_W           = 16
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [7:0]  sw,
   input  logic [3:0]  btn,
   input  logic        done,
   output logic [31:0] operand_a,
   output logic [31:0] operand_b,
   output logic [1:0]  op,
   output logic        start,
   output logic [1:0]  state
);

   typedef enum logic [1:0] {
      ENTER_A  = 2'd0,
      ENTER_B  = 2'd1,
      ENTER_OP = 2'd2,
      WAIT     = 2'd3
   } state_t;

   if (DEBOUNCE_CYCLES < 2 || (DEBOUNCE_CYCLES >> CNT_W) != 0) begin : g_cfg_err
      $error("key_dev: DEBOUNCE_CYCLES must be >= 2 and fit in CNT_W bits");
   end

   logic [7:0] sw_p0, sw_p1;
   logic [3:0] btn_p0, btn_p1;
   logic [3:0] lvl, lvl_q, press;

   // stage p0/p1: two-flop synchronizers on every raw input bit
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sw_p0  <= '0;
         sw_p1  <= '0;
         btn_p0 <= '0;
         btn_p1 <= '0;
      end else begin
         sw_p0  <= sw;
         sw_p1  <= sw_p0;
         btn_p0 <= btn;
         btn_p1 <= btn_p0;
      end
   end

`ifdef KEY_DEV_DEBOUNCE_EN
   for (genvar g = 0; g < 4; g++) begin : g_db
      logic [CNT_W-1:0] cnt;
      logic             lvl_b;

      // counter tracks how long the input has disagreed with the accepted level
      always_ff @(posedge clk or posedge rst) begin
         if (rst) begin
            cnt   <= '0;
            lvl_b <= 1'b0;
         end else if (btn_p1[g] == lvl_b) begin
            cnt <= '0;
         end else if (cnt == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
            cnt   <= '0;
            lvl_b <= ~lvl_b;
         end else begin
            cnt <= cnt + 1'b1;
         end
      end

      assign lvl[g] = lvl_b;
   end
`else
   assign lvl = btn_p1;
`endif

   // press pulse: one cycle after the accepted level rises
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         lvl_q <= '0;
         press <= '0;
      end else begin
         lvl_q <= lvl;
         press <= lvl & ~lvl_q;
      end
   end

   state_t      st, st_nx;
   logic [31:0] a_nx, b_nx;
   logic [1:0]  op_nx;
   logic        start_nx;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         st        <= ENTER_A;
         operand_a <= '0;
         operand_b <= '0;
         op        <= '0;
         start     <= 1'b0;
      end else begin
         st        <= st_nx;
         operand_a <= a_nx;
         operand_b <= b_nx;
         op        <= op_nx;
         start     <= start_nx;
      end
   end

   // priority: clear > (WAIT handling) > go > next > shift
   always_comb begin
      st_nx    = st;
      a_nx     = operand_a;
      b_nx     = operand_b;
      op_nx    = op;
      start_nx = 1'b0;
      if (press[3]) begin
         st_nx = ENTER_A;
         a_nx  = '0;
         b_nx  = '0;
         op_nx = '0;
      end else if (st == WAIT) begin
         if (done)
            st_nx = ENTER_A;
      end else if (press[2]) begin
         st_nx    = WAIT;
         start_nx = 1'b1;
      end else if (press[1]) begin
         case (st)
            ENTER_A:  st_nx = ENTER_B;
            ENTER_B:  st_nx = ENTER_OP;
            default:  st_nx = ENTER_A;
         endcase
      end else if (press[0]) begin
         case (st)
            ENTER_A:  a_nx  = {operand_a[23:0], sw_p1};
            ENTER_B:  b_nx  = {operand_b[23:0], sw_p1};
            default:  op_nx = sw_p1[1:0];
         endcase
      end
   end

   assign state = st;

endmodule

// File: doc/key_dev.md
KEY_DEV -- requirements
Module: key_dev

Interface
REQ-001 The block SHALL have parameter DEBOUNCE_CYCLES, default 50000, giving the consecutive stable cycles required to accept a level change (minimum 2).
REQ-002 The block SHALL have parameter CNT_W, default 16, giving the debounce counter width (2^CNT_W > DEBOUNCE_CYCLES).
REQ-003 clk  in  1  the single system clock; all state SHALL update on its rising edge.
REQ-004 rst  in  1  reset, asynchronous, active-high.
REQ-005 sw  in  8  raw slide switches, asynchronous to clk.
REQ-006 btn  in  4  raw push buttons, asynchronous to clk, active-high: [0] shift, [1] next, [2] go, [3] clear.
REQ-007 done  in  1  one-cycle completion pulse from the ALU.
REQ-008 operand_a  out  32  registered first operand.
REQ-009 operand_b  out  32  registered second operand.
REQ-010 op  out  2  registered opcode.
REQ-011 start  out  1  registered one-cycle request pulse to the ALU.
REQ-012 state  out  2  current FSM state code, for display.

Function
REQ-013 Each sw and btn bit SHALL pass through a 2-flop synchronizer before any other use.
REQ-014 Each btn bit SHALL have its own debouncer: a counter that clears whenever the synchronized input equals the debounced level; the debounced level SHALL flip when the input has differed for DEBOUNCE_CYCLES consecutive cycles, and the counter SHALL then clear.
REQ-015 Each btn bit SHALL produce a press pulse, high for exactly one cycle on the cycle after its debounced level rises. Releases produce no pulse.
REQ-016 A glitch shorter than DEBOUNCE_CYCLES cycles SHALL NOT change the debounced level or produce a pulse.
REQ-017 The FSM SHALL have four states: ENTER_A=0, ENTER_B=1, ENTER_OP=2, WAIT=3.
REQ-018 shift in ENTER_A SHALL load operand_a <= {operand_a[23:0], sw}.
REQ-019 shift in ENTER_B SHALL load operand_b <= {operand_b[23:0], sw}.
REQ-020 shift in ENTER_OP SHALL load op <= sw[1:0].
REQ-021 next SHALL advance ENTER_A->ENTER_B->ENTER_OP->ENTER_A, wrapping around.
REQ-022 go in any ENTER_* state SHALL assert start for one cycle (the next cycle) and enter WAIT.
REQ-023 In WAIT, shift, next and go SHALL be ignored; done SHALL return the FSM to ENTER_A with operands and op retained.
REQ-024 done outside WAIT SHALL be ignored.
REQ-025 clear in any state, including WAIT, SHALL zero operand_a, operand_b and op, and force ENTER_A; start SHALL not assert.
REQ-026 When several press pulses coincide in one cycle, only the highest-priority one SHALL act: clear > go > next > shift.
REQ-027 If done and clear coincide in WAIT, clear SHALL take effect.
REQ-028 Operands and op SHALL change only as stated above; outputs SHALL be held stable otherwise.

Reset
REQ-029 While rst is high, state SHALL be ENTER_A; operand_a, operand_b, op and start SHALL be 0; all synchronizer flops, debounced levels and counters SHALL be 0.
REQ-030 Reset asserted mid-debounce or in WAIT SHALL abort immediately with no start pulse.
REQ-031 A button held through reset release SHALL produce exactly one press pulse after debouncing completes.

Configuration
REQ-032 With macro KEY_DEV_DEBOUNCE_EN defined, the debouncers of REQ-014 SHALL be built.
REQ-033 Without KEY_DEV_DEBOUNCE_EN, the debounced level SHALL equal the synchronized input and no counters SHALL exist; all other behaviour is unchanged, and DEBOUNCE_CYCLES SHALL be ignored.

Verification (DEBOUNCE_CYCLES=4, KEY_DEV_DEBOUNCE_EN defined unless noted)
REQ-034 Entry: sw=0x3F, shift x4 -> operand_a=0x3F3F3F3F; next; sw=0x40, shift x2 -> operand_b=0x00004040; next; sw=0x02, shift -> op=2, state=2.
REQ-035 Issue: go from ENTER_OP -> start high exactly one cycle and state=3; shift and next pressed in WAIT -> operands unchanged; done -> state=0, operand_a still 0x3F3F3F3F.
REQ-036 Debounce: a 3-cycle btn[0] glitch -> no pulse; btn[0] held 20 cycles -> exactly one pulse.
REQ-037 Priority: btn[2] and btn[0] rise together -> start pulses and operand unchanged; btn[3] and done together in WAIT -> all zero and state=0.
REQ-038 Reset: rst asserted in WAIT -> state=0, outputs 0, no start; rst released with btn[1] held -> one next pulse, giving state=1.
REQ-039 Without KEY_DEV_DEBOUNCE_EN: a btn[0] rise produces a pulse after only the 2-flop synchronizer delay, and a 1-cycle-wide btn input still yields one shift.
